seg_scan_driver: RTL and testbench

//  Sink for the digit formatter's data/DP/Blank flags. Drives a time-multiplexed 6-digit seven-segment bank.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_scan_driver_if.sv | 21 ++
 rtl/seg_hex_decode.sv | 17 +
 rtl/seg_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
//  Module  : seg_pkg
//  Purpose : Shared scan-state type and seven-segment constants for the
//            seven-segment scan driver.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  localparam int N_DIGITS_DEF = 6;

  // Segment order gfedcba, active low.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/seg_scan_driver_if.sv
// ============================================================================
//  Module  : seg_scan_driver_if
//  Purpose : Frame hand-off from the digit formatter to the scan driver.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg_scan_driver_if #(
  parameter int N_DIGITS = 6
);
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_data;
  logic [N_DIGITS-1:0] in_dp;
  logic [N_DIGITS-1:0] in_blank;

  modport master (output in_valid, in_data, in_dp, in_blank, input in_ready);
  modport slave  (input in_valid, in_data, in_dp, in_blank, output in_ready);
endinterface

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
//  Module  : seg_hex_decode
//  Purpose : Combinational hex nibble to active-low gfedcba segment decode.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  assign seg_n = SEG_HEX[nibble];
endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
//  Module  : seg_scan_driver
//  Purpose : Tear-free, ghost-suppressed multiplexed seven-segment scanner.
//            Optional brightness control: define SEG_SCAN_DIM_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS  = N_DIGITS_DEF,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  seg_scan_driver_if.slave    in_if,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]          dim_level,
`endif
  output logic [N_DIGITS-1:0] an_n,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic                frame_done
);

  localparam int c_cnt_w = $clog2(SCAN_DIV);
  localparam int c_idx_w = $clog2(N_DIGITS);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_guard_end = c_cnt_w'(GUARD_CYC - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(N_DIGITS - 1);

  scan_state_t         r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_idx;
  logic                w_tick, w_boundary, w_commit, w_accept, w_dim_on;

  logic                r_pend_full;
  logic [15:0]         r_pend_data, r_act_data;
  logic [N_DIGITS-1:0] r_pend_dp, r_pend_blank, r_act_dp, r_act_blank;

  logic [3:0]          w_nibble;
  logic [6:0]          w_seg_hex, w_seg_nxt, r_seg_n;
  logic [N_DIGITS-1:0] w_an_nxt, r_an_n;
  logic                w_dp_nxt, r_dp_n, r_frame_done;

  assign w_tick     = (r_cnt == c_cnt_last);
  assign w_boundary = w_tick && (r_idx == c_idx_last);
  assign w_commit   = w_boundary && r_pend_full;
  assign in_if.in_ready = !r_pend_full || w_commit;
  assign w_accept   = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick)
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
    end
  end

  // Single-entry frame buffer; active copy only changes at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_full  <= 1'b0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
    end else begin
      if (w_commit) begin
        r_act_data  <= r_pend_data;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
      end
      if (w_accept) begin
        r_pend_full  <= 1'b1;
        r_pend_data  <= in_if.in_data;
        r_pend_dp    <= in_if.in_dp;
        r_pend_blank <= in_if.in_blank;
      end else if (w_commit) begin
        r_pend_full <= 1'b0;
      end
    end
  end

`ifdef SEG_SCAN_DIM_EN
  localparam logic [c_cnt_w-1:0] c_sub_last = c_cnt_w'((SCAN_DIV - GUARD_CYC) / 8 - 1);
  logic [2:0]         r_dim, r_win;
  logic [c_cnt_w-1:0] r_win_cnt;

  // Drive phase is cut into 8 equal sub-windows tracked by r_win.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dim     <= 3'd7;
      r_win     <= '0;
      r_win_cnt <= '0;
    end else begin
      if (r_cnt == '0)
        r_dim <= dim_level;
      if (r_state == S_GUARD) begin
        r_win     <= '0;
        r_win_cnt <= '0;
      end else if (r_win_cnt == c_sub_last) begin
        r_win     <= r_win + 1'b1;
        r_win_cnt <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end
    end
  end

  assign w_dim_on = (r_win <= r_dim);
`else
  assign w_dim_on = 1'b1;
`endif

  assign w_nibble = (int'(r_idx) < 4) ? r_act_data[{r_idx[1:0], 2'b00} +: 4] : 4'h0;

  seg_hex_decode u_hex (
    .nibble (w_nibble),
    .seg_n  (w_seg_hex)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_an_nxt    = '1;
    w_seg_nxt   = SEG_OFF;
    w_dp_nxt    = 1'b1;
    unique case (r_state)
      S_GUARD: if (r_cnt == c_guard_end) w_state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (w_tick) w_state_nxt = S_GUARD;
        if (!r_act_blank[r_idx] && w_dim_on) begin
          w_an_nxt  = ~(N_DIGITS'(1) << r_idx);
          w_seg_nxt = w_seg_hex;
          w_dp_nxt  = ~r_act_dp[r_idx];
        end
      end
      default: w_state_nxt = S_GUARD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_n       <= '1;
      r_seg_n      <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an_n       <= w_an_nxt;
      r_seg_n      <= w_seg_nxt;
      r_dp_n       <= w_dp_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign an_n       = r_an_n;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
//  Module  : tb_seg_scan_driver
//  Purpose : Randomized scoreboard bench for seg_scan_driver (SCAN_DIV=40, GUARD_CYC=8).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

  localparam int ND    = 6;
  localparam int SD    = 40;
  localparam int GC    = 8;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.N_DIGITS(ND)) bus ();
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic          dp_n, frame_done;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]    dim_level = 3'd7;
`endif

  seg_scan_driver #(.N_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus.slave),
`ifdef SEG_SCAN_DIM_EN
    .dim_level  (dim_level),
`endif
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [15:0]   data;
    logic [ND-1:0] dp;
    logic [ND-1:0] blank;
  } frame_t;

  typedef struct {
    int     slot;
    frame_t f;
    int     dim;
  } slot_exp_t;

  int        vectors = 0;
  int        miscompares = 0;
  slot_exp_t sb[$];
  frame_t    pend[$];
  frame_t    active;
  int        t = 0;
  int        slot_dim = 7;
  bit        mon_en = 1'b0;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, req, t);
    end
  endtask

  // Reference model: frame-level view of buffer, commit and scan timing.
  int cnt_m;
  bit bnd_m;
  always @(negedge clk) begin
    if (reset) begin
      t = 0;
      pend.delete();
      sb.delete();
      active   = '{16'h0, 6'h00, 6'h3F};
      slot_dim = 7;
    end else begin
      cnt_m = t % SD;
      bnd_m = (t % FRAME) == FRAME - 1;
      check("in_ready", 64'(bus.in_ready), 64'((pend.size() == 0) || bnd_m));
`ifdef SEG_SCAN_DIM_EN
      if (cnt_m == 0) slot_dim = int'(dim_level);
`endif
      if (cnt_m == SD - 1 && t >= FRAME) sb.push_back('{(t / SD) % ND, active, slot_dim});
      if (bnd_m && pend.size() != 0) active = pend.pop_front();
      if (bus.in_valid && bus.in_ready) pend.push_back('{bus.in_data, bus.in_dp, bus.in_blank});
      t++;
    end
  end

  // Monitor: frame_done sync, then one summary per 40-cycle slot window.
  initial begin : monitor
    int n, on_cnt, first_on, last_on, exp_on;
    logic [ND-1:0] an_v, exp_an;
    logic [6:0] seg_v, exp_seg;
    logic dp_v, exp_dp, bad, lit_dark, blank_e;
    logic [15:0] dsh;
    slot_exp_t e;
    wait (mon_en);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 1000);
    if (!frame_done) check("first_frame_done", 64'd0, 64'd1);
    else forever begin
      for (int s = 0; s < ND; s++) begin
        on_cnt = 0; first_on = 63; last_on = 0; bad = 0; lit_dark = 0;
        an_v = '1; seg_v = 7'h7F; dp_v = 1'b1;
        for (int m = 0; m < SD; m++) begin
          @(negedge clk);
          if ($isunknown({an_n, seg_n, dp_n, frame_done})) bad = 1;
          else begin
            if (frame_done !== 1'((s == ND - 1) && (m == SD - 1))) bad = 1;
            if (an_n == '1) begin
              if (seg_n != 7'h7F || dp_n != 1'b1) begin
                if (m < GC) bad = 1;
                else lit_dark = 1;
              end
            end else if ($countones(~an_n) == 1) begin
              if (on_cnt == 0) begin
                first_on = m; an_v = an_n; seg_v = seg_n; dp_v = dp_n;
              end else if ({an_n, seg_n, dp_n} != {an_v, seg_v, dp_v}) bad = 1;
              on_cnt++;
              last_on = m;
            end else bad = 1;
          end
        end
        if (on_cnt > 0 && last_on - first_on + 1 != on_cnt) bad = 1;
        if (sb.size() == 0) check("scoreboard_underflow", 64'd0, 64'd1);
        else begin
          e = sb.pop_front();
          blank_e = e.f.blank[e.slot];
`ifdef SEG_SCAN_DIM_EN
          exp_on = blank_e ? 0 : ((SD - GC) / 8) * (e.dim + 1);
`else
          exp_on = blank_e ? 0 : (SD - GC);
`endif
          dsh     = (e.slot < 4) ? (e.f.data >> (4 * e.slot)) : 16'h0;
          exp_an  = (exp_on != 0) ? ~(ND'(1) << e.slot) : '1;
          exp_seg = (exp_on != 0) ? hex7(dsh[3:0]) : 7'h7F;
          exp_dp  = (exp_on != 0) ? ~e.f.dp[e.slot] : 1'b1;
          check($sformatf("slot%0d{idx,on,first,an,seg,dp,bad}", s),
                64'({4'(s), 6'(on_cnt), 6'(first_on), an_v, seg_v, dp_v, bad | (blank_e & lit_dark)}),
                64'({4'(e.slot), 6'(exp_on), 6'((exp_on != 0) ? GC : 63), exp_an, exp_seg, exp_dp, 1'b0}));
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [ND-1:0] p, input logic [ND-1:0] b);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_dp = p; bus.in_blank = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("send_timeout_in_ready", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dp = '0; bus.in_blank = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_an_n", 64'(an_n), 64'h3F);
    check("reset_seg_n", 64'(seg_n), 64'h7F);
    check("reset_dp_n", 64'(dp_n), 64'h1);
    check("reset_frame_done", 64'(frame_done), 64'h0);

    // Show a frame, then reset in the middle of slot 3's drive phase.
    send(16'h4321, 6'b001000, 6'b000000);
    do @(posedge clk); while (t != 2 * FRAME - 100);
    #1;
    @(negedge clk);
    check("pre_reset_slot3_an_n", 64'(an_n), 64'h37);
    check("pre_reset_slot3_seg_n", 64'(seg_n), 64'(hex7(4'h4)));
    check("pre_reset_slot3_dp_n", 64'(dp_n), 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midslot_reset_an_n", 64'(an_n), 64'h3F);
    check("midslot_reset_seg_n", 64'(seg_n), 64'h7F);
    check("midslot_reset_dp_n", 64'(dp_n), 64'h1);
    mon_en = 1'b1;

    send(16'h1A2F, 6'b000000, 6'b110000);
    wait_cycles(2 * FRAME);

    send(16'(($urandom)), 6'($urandom), 6'b000000);
    send(16'(($urandom)), 6'($urandom), 6'b000000);
    wait_cycles(2 * FRAME);

    send(16'h5A5A, 6'b111111, 6'b000000);
    send(16'hBEEF, 6'b000000, 6'b000001);
    wait_cycles(3 * FRAME);

    send(16'(($urandom)), 6'b000100, 6'b000100);
    send(16'(($urandom)), 6'b000100, 6'b000000);
    wait_cycles(3 * FRAME);

`ifdef SEG_SCAN_DIM_EN
    dim_level = 3'd3;
    send(16'h9876, 6'b010101, 6'b000000);
    wait_cycles(2 * FRAME);
    dim_level = 3'd7;
    wait_cycles(FRAME);
`endif

    repeat (8) begin
      send(16'(($urandom)), 6'($urandom), 6'($urandom & $urandom));
`ifdef SEG_SCAN_DIM_EN
      dim_level = 3'($urandom);
`endif
      wait_cycles($urandom_range(0, 300));
    end
    wait_cycles(3 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
